// File: rtl/wt_disp_scan_ctrl.sv
// Six-digit 7-segment scan controller: time-shares one binary-to-BCD separator across HOUR/MIN/SEC.
// Optional macro WT_LZ_BLANK_EN blanks a leading zero on the hour tens digit.
module wt_disp_scan_ctrl #(
  parameter int SCAN_DIV = 1000,
  parameter int PRE_W    = 10
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [6:0] HOUR,
  input  logic [6:0] MIN,
  input  logic [6:0] SEC,
  output logic [6:0] SEP_NUM,
  input  logic [3:0] SEP_A,
  input  logic [3:0] SEP_B,
  output logic [5:0] DIGIT_SEL,
  output logic [3:0] DIGIT_BCD,
  output logic       FRAME_DONE
);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LATCH  = 2'd2;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [1:0]       state;
  logic [2:0]       idx;
  logic [6:0]       sh_h, sh_m, sh_s;
  logic [6:0]       field;
  logic [6:0]       sep_load;
  logic [5:0]       sel_nxt;
  logic [3:0]       bcd_nxt;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) pre <= '0;
    else         pre <= tick ? '0 : pre + PRE_W'(1);
  end

  always_comb begin
    field = sh_s;
    case (idx[2:1])
      2'd0:    field = sh_h;
      2'd1:    field = sh_m;
      default: field = sh_s;
    endcase
  end

  // Slot 0 opens a new frame, so the separator sees the freshly sampled HOUR.
  assign sep_load = (idx == 3'd0) ? HOUR : field;

  always_comb begin
    sel_nxt = ~(6'b100000 >> idx);
    bcd_nxt = idx[0] ? SEP_B : SEP_A;
`ifdef WT_LZ_BLANK_EN
    if (idx == 3'd0 && SEP_A == 4'd0) begin
      sel_nxt = 6'b111111;
      bcd_nxt = 4'd0;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= ST_WAIT;
      idx        <= 3'd0;
      sh_h       <= 7'd0;
      sh_m       <= 7'd0;
      sh_s       <= 7'd0;
      SEP_NUM    <= 7'd0;
      DIGIT_SEL  <= 6'b111111;
      DIGIT_BCD  <= 4'd0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (tick) begin
            if (idx == 3'd0) begin
              sh_h <= HOUR;
              sh_m <= MIN;
              sh_s <= SEC;
            end
            SEP_NUM <= sep_load;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: state <= ST_LATCH;
        ST_LATCH: begin
          DIGIT_BCD  <= bcd_nxt;
          DIGIT_SEL  <= sel_nxt;
          FRAME_DONE <= (idx == 3'd5);
          idx        <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
          state      <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_wt_disp_scan_ctrl.sv
// Bench for wt_disp_scan_ctrl: reference separator plus a slot-timeline model of the display.
module tb_wt_disp_scan_ctrl;
  localparam int SD = 4;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [6:0] HOUR = 7'd0, MIN = 7'd0, SEC = 7'd0;
  logic [6:0] SEP_NUM;
  logic [3:0] SEP_A, SEP_B, DIGIT_BCD;
  logic [5:0] DIGIT_SEL;
  logic       FRAME_DONE;
  int total = 0;
  int bad = 0;

  wt_disp_scan_ctrl #(.SCAN_DIV(SD), .PRE_W(3)) dut (
    .CLK(CLK), .RESETN(RESETN), .HOUR(HOUR), .MIN(MIN), .SEC(SEC),
    .SEP_NUM(SEP_NUM), .SEP_A(SEP_A), .SEP_B(SEP_B),
    .DIGIT_SEL(DIGIT_SEL), .DIGIT_BCD(DIGIT_BCD), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Reference separator: out-of-range numbers come back as 0,0.
  function automatic logic [3:0] ref_tens(input logic [6:0] n);
    return (n > 7'd99) ? 4'd0 : 4'(n / 7'd10);
  endfunction
  function automatic logic [3:0] ref_units(input logic [6:0] n);
    return (n > 7'd99) ? 4'd0 : 4'(n % 7'd10);
  endfunction

  assign SEP_A = ref_tens(SEP_NUM);
  assign SEP_B = ref_units(SEP_NUM);

  // Timeline model: slot s ticks at edge SD*(s+1) after release, shows at +2.
  int         cyc;
  logic [6:0] sn_h, sn_m, sn_s;
  logic [5:0] exp_sel;
  logic [3:0] exp_bcd;
  logic [6:0] exp_sep;
  logic       exp_fd;

  function automatic logic [6:0] snap_field(input int k);
    if (k < 2) return sn_h;
    if (k < 4) return sn_m;
    return sn_s;
  endfunction

  always @(posedge CLK or negedge RESETN) begin : model
    int c, k;
    logic [6:0] num;
    logic [5:0] s;
    if (!RESETN) begin
      cyc <= 0; sn_h <= 7'd0; sn_m <= 7'd0; sn_s <= 7'd0;
      exp_sel <= 6'h3F; exp_bcd <= 4'd0; exp_sep <= 7'd0; exp_fd <= 1'b0;
    end else begin
      c = cyc + 1;
      cyc <= c;
      exp_fd <= 1'b0;
      if (c >= SD && (c - SD) % SD == 0) begin
        k = ((c - SD) / SD) % 6;
        if (k == 0) begin
          sn_h <= HOUR; sn_m <= MIN; sn_s <= SEC;
          exp_sep <= HOUR;
        end else exp_sep <= snap_field(k);
      end
      if (c >= SD + 2 && (c - SD - 2) % SD == 0) begin
        k = ((c - SD - 2) / SD) % 6;
        num = snap_field(k);
        s = 6'h3F;
        s[5 - k] = 1'b0;
        exp_sel <= s;
        exp_bcd <= (k % 2 == 1) ? ref_units(num) : ref_tens(num);
        exp_fd  <= (k == 5);
`ifdef WT_LZ_BLANK_EN
        if (k == 0 && ref_tens(num) == 4'd0) begin
          exp_sel <= 6'h3F;
          exp_bcd <= 4'd0;
        end
`endif
      end
    end
  end

  task automatic do_reset(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    @(negedge CLK);
    RESETN = 1'b0; HOUR = h; MIN = m; SEC = s;
    @(negedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  task automatic test_reset;
    int n;
    HOUR = 7'd23; MIN = 7'd45; SEC = 7'd7;
    RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (DIGIT_SEL !== 6'h3F || DIGIT_BCD !== 4'd0 || SEP_NUM !== 7'd0 || FRAME_DONE !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: sel=%b bcd=%0d sep=%0d fd=%b, want sel=111111 bcd=0 sep=0 fd=0",
               DIGIT_SEL, DIGIT_BCD, SEP_NUM, FRAME_DONE);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    n = 0;
    while (DIGIT_SEL === 6'h3F && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    total++;
    if (n != SD + 2 || DIGIT_SEL !== 6'b011111) begin
      bad++;
      $display("FAIL first_digit: edges=%0d sel=%b, want edges=%0d sel=011111", n, DIGIT_SEL, SD + 2);
    end
  endtask

  task automatic test_frame;
    logic [3:0] fb [6];
    logic [5:0] fs [6];
    fb = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd7};
    fs = '{6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};
    do_reset(7'd23, 7'd45, 7'd7);
    repeat (SD + 2) @(posedge CLK);
    #1;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (DIGIT_SEL !== fs[k] || DIGIT_BCD !== fb[k] || FRAME_DONE !== (k == 5)) begin
        bad++;
        $display("FAIL frame_digit%0d: sel=%b bcd=%0d fd=%b, want sel=%b bcd=%0d fd=%0d",
                 k, DIGIT_SEL, DIGIT_BCD, FRAME_DONE, fs[k], fb[k], (k == 5));
      end
      for (int j = 1; j < SD; j++) begin
        @(posedge CLK); #1;
        total++;
        if (DIGIT_SEL !== fs[k] || DIGIT_BCD !== fb[k] || FRAME_DONE !== 1'b0) begin
          bad++;
          $display("FAIL frame_hold%0d: sel=%b bcd=%0d fd=%b, want sel=%b bcd=%0d fd=0",
                   k, DIGIT_SEL, DIGIT_BCD, FRAME_DONE, fs[k], fb[k]);
        end
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_snapshot;
    logic [3:0] rec[$];
    logic [5:0] prev;
    int n;
    do_reset(7'd23, 7'd45, 7'd7);
    repeat (3 * SD) @(posedge CLK);
    #1;
    SEC = 7'd8;
    prev = DIGIT_SEL;
    n = 0;
    while (rec.size() < 10 && n < 12 * SD) begin
      @(posedge CLK); #1; n++;
      if (DIGIT_SEL !== prev) begin
        rec.push_back(DIGIT_BCD);
        prev = DIGIT_SEL;
      end
    end
    total++;
    if (rec.size() != 10) begin
      bad++;
      $display("FAIL snap_count: digits=%0d, want 10", rec.size());
    end else begin
      total++;
      if (rec[2] !== 4'd0 || rec[3] !== 4'd7) begin
        bad++;
        $display("FAIL snap_cur_frame: sec digits=%0d,%0d, want 0,7", rec[2], rec[3]);
      end
      total++;
      if (rec[8] !== 4'd0 || rec[9] !== 4'd8) begin
        bad++;
        $display("FAIL snap_next_frame: sec digits=%0d,%0d, want 0,8", rec[8], rec[9]);
      end
    end
  endtask

  task automatic test_range;
    logic [5:0] s0;
`ifdef WT_LZ_BLANK_EN
    s0 = 6'b111111;
`else
    s0 = 6'b011111;
`endif
    do_reset(7'd120, 7'd45, 7'd7);
    repeat (SD) @(posedge CLK);
    #1;
    total++;
    if (SEP_NUM !== 7'd120) begin
      bad++; $display("FAIL range_sep0: sep=%0d, want 120", SEP_NUM);
    end
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (DIGIT_SEL !== s0 || DIGIT_BCD !== 4'd0) begin
      bad++; $display("FAIL range_slot0: sel=%b bcd=%0d, want sel=%b bcd=0", DIGIT_SEL, DIGIT_BCD, s0);
    end
    repeat (SD - 2) @(posedge CLK);
    #1;
    total++;
    if (SEP_NUM !== 7'd120) begin
      bad++; $display("FAIL range_sep1: sep=%0d, want 120", SEP_NUM);
    end
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (DIGIT_SEL !== 6'b101111 || DIGIT_BCD !== 4'd0) begin
      bad++; $display("FAIL range_slot1: sel=%b bcd=%0d, want sel=101111 bcd=0", DIGIT_SEL, DIGIT_BCD);
    end
    repeat (SD) @(posedge CLK);
    #1;
    total++;
    if (DIGIT_SEL !== 6'b110111 || DIGIT_BCD !== 4'd4) begin
      bad++; $display("FAIL range_slot2: sel=%b bcd=%0d, want sel=110111 bcd=4", DIGIT_SEL, DIGIT_BCD);
    end
  endtask

  task automatic test_async_reset;
    do_reset(7'd23, 7'd45, 7'd7);
    repeat (4 * SD) @(posedge CLK);
    #1;
    total++;
    if (DIGIT_SEL !== 6'b110111 || SEP_NUM !== 7'd45) begin
      bad++; $display("FAIL arst_pre: sel=%b sep=%0d, want sel=110111 sep=45", DIGIT_SEL, SEP_NUM);
    end
    #1 RESETN = 1'b0;
    #1;
    total++;
    if (DIGIT_SEL !== 6'h3F || DIGIT_BCD !== 4'd0 || SEP_NUM !== 7'd0 || FRAME_DONE !== 1'b0) begin
      bad++;
      $display("FAIL arst_now: sel=%b bcd=%0d sep=%0d fd=%b, want 111111/0/0/0",
               DIGIT_SEL, DIGIT_BCD, SEP_NUM, FRAME_DONE);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    repeat (SD + 1) @(posedge CLK);
    #1;
    total++;
    if (DIGIT_SEL !== 6'h3F) begin
      bad++; $display("FAIL arst_early: sel=%b, want 111111", DIGIT_SEL);
    end
    @(posedge CLK); #1;
    total++;
    if (DIGIT_SEL !== 6'b011111 || DIGIT_BCD !== 4'd2) begin
      bad++; $display("FAIL arst_restart: sel=%b bcd=%0d, want sel=011111 bcd=2", DIGIT_SEL, DIGIT_BCD);
    end
  endtask

  task automatic test_lz;
    logic [5:0] s0;
`ifdef WT_LZ_BLANK_EN
    s0 = 6'b111111;
`else
    s0 = 6'b011111;
`endif
    do_reset(7'd5, 7'd45, 7'd7);
    repeat (SD + 2) @(posedge CLK);
    #1;
    total++;
    if (DIGIT_SEL !== s0 || DIGIT_BCD !== 4'd0) begin
      bad++; $display("FAIL lz_hour_tens: sel=%b bcd=%0d, want sel=%b bcd=0", DIGIT_SEL, DIGIT_BCD, s0);
    end
    repeat (SD) @(posedge CLK);
    #1;
    total++;
    if (DIGIT_SEL !== 6'b101111 || DIGIT_BCD !== 4'd5) begin
      bad++; $display("FAIL lz_hour_units: sel=%b bcd=%0d, want sel=101111 bcd=5", DIGIT_SEL, DIGIT_BCD);
    end
  endtask

  task automatic test_random;
    do_reset(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
    for (int i = 0; i < 8 * 6 * SD; i++) begin
      @(posedge CLK); #1;
      total++;
      if ({DIGIT_SEL, DIGIT_BCD, SEP_NUM, FRAME_DONE} !== {exp_sel, exp_bcd, exp_sep, exp_fd}) begin
        bad++;
        $display("FAIL rand_cycle%0d: sel=%b bcd=%0d sep=%0d fd=%b, want sel=%b bcd=%0d sep=%0d fd=%b",
                 i, DIGIT_SEL, DIGIT_BCD, SEP_NUM, FRAME_DONE, exp_sel, exp_bcd, exp_sep, exp_fd);
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       HOUR = 7'($urandom_range(0, 127));
          1:       MIN  = 7'($urandom_range(0, 127));
          default: SEC  = 7'($urandom_range(0, 127));
        endcase
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_snapshot;
    test_range;
    test_async_reset;
    test_lz;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wt_disp_scan_ctrl.md
Name: wt_disp_scan_ctrl

Overview:
- Scan controller for the watch's six-digit 7-segment display.
- Time-shares one external number-to-digit separator (7-bit binary in; tens/units BCD nibbles out, combinational) among the HOUR, MIN and SEC fields.
- Sequences the separator one digit per scan slot and drives a one-hot active-low digit select together with the matching BCD digit.
- Sits between the timekeeping counters and the BCD-to-segment decoder.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot. Must be >= 4.
- PRE_W, 10: prescaler width. Must satisfy 2^PRE_W >= SCAN_DIV.

Ports:
- CLK  in  1  system clock, rising edge.
- RESETN  in  1  asynchronous active-low reset.
- HOUR  in  7  hours, binary 0..99.
- MIN  in  7  minutes, binary 0..99.
- SEC  in  7  seconds, binary 0..99.
- SEP_NUM  out  7  registered number to the shared separator.
- SEP_A  in  4  separator tens nibble.
- SEP_B  in  4  separator units nibble.
- DIGIT_SEL  out  6  active-low one-hot digit enable. Bit5 = hour tens, bit0 = second units.
- DIGIT_BCD  out  4  BCD value for the enabled digit.
- FRAME_DONE  out  1  one-cycle pulse when digit index 5 is latched.

Behaviour:
- Clock and reset are decided: one clock, CLK; reset RESETN is asynchronous, active-low.
- Reset values:
  - prescaler PRE = 0, IDX = 0, state = WAIT
  - SEP_NUM = 0, DIGIT_SEL = 6'b111111 (all off), DIGIT_BCD = 0, FRAME_DONE = 0
  - shadow registers SH_H, SH_M, SH_S = 0
- Prescaler:
  - PRE counts 0..SCAN_DIV-1 and wraps, free-running in every state.
  - TICK = (PRE == SCAN_DIV-1).
- IDX counts 0..5 and selects the digit: 0 = hour tens, 1 = hour units, 2 = min tens, 3 = min units, 4 = sec tens, 5 = sec units.
- Field select: IDX/2 (0 = SH_H, 1 = SH_M, 2 = SH_S).
- Nibble select: even IDX takes SEP_A, odd IDX takes SEP_B.
- FSM states:
  - WAIT: on TICK, load SEP_NUM with the selected shadow field and go to SETTLE. If IDX == 0 on that same TICK, first load SH_H/SH_M/SH_S from HOUR/MIN/SEC, and SEP_NUM uses the newly sampled HOUR.
  - SETTLE: one cycle for the separator to settle; go to LATCH unconditionally.
  - LATCH:
    - Load DIGIT_BCD with the selected nibble.
    - Load DIGIT_SEL with ~(6'b100000 >> IDX).
    - FRAME_DONE = 1 if IDX == 5.
    - IDX increments, wrapping 5 -> 0.
    - Go to WAIT.
- Latency: DIGIT_SEL and DIGIT_BCD change together on the 3rd rising edge after the TICK edge. They hold for the rest of the slot, giving SCAN_DIV cycles per digit and 6*SCAN_DIV cycles per frame.
- Snapshot: inputs are sampled once per frame, so all six digits of a frame come from one coherent time value. Input changes mid-frame appear only in the next frame.
- Value range: fields > 99 pass to the separator unchanged; the digits shown are whatever SEP_A/SEP_B return. The controller does no range check.
- SEP_NUM changes only in WAIT on TICK, so it is stable for the whole SETTLE/LATCH window.
- Reset mid-scan: all outputs return to reset values immediately (asynchronous). The first digit after release is IDX 0, latched on the 3rd edge after the first TICK, which falls SCAN_DIV-1 cycles after release.

Optional Feature:
- Macro: WT_LZ_BLANK_EN.
- Defined: leading-zero blanking on the hour tens digit. When IDX == 0 and SEP_A == 0 in LATCH, DIGIT_SEL = 6'b111111 for that slot (digit off) and DIGIT_BCD = 0. Timing and IDX sequencing are unchanged.
- Undefined: hour tens is always enabled, so 0 is displayed.

Test Plan:
- Reset: hold RESETN = 0 -> DIGIT_SEL = 6'b111111, DIGIT_BCD = 0, SEP_NUM = 0, FRAME_DONE = 0. Release -> first DIGIT_SEL = 6'b011111 exactly SCAN_DIV+2 edges after release.
- Normal frame, SCAN_DIV = 4, with a reference separator: HOUR = 23, MIN = 45, SEC = 7 -> DIGIT_BCD sequence 2,3,4,5,0,7 with DIGIT_SEL 011111, 101111, 110111, 111011, 111101, 111110. Each digit lasts 4 cycles. FRAME_DONE pulses once, in the same cycle as DIGIT_SEL = 111110.
- Snapshot coherency: change SEC from 7 to 8 while IDX = 2 -> the current frame still shows 0,7; the next frame shows 0,8.
- Out of range: HOUR = 120 -> SEP_NUM = 120 in hour slots; DIGIT_BCD = separator outputs (0,0); sequencing unaffected.
- Async reset at IDX = 3 in SETTLE -> outputs reset the same cycle; next frame restarts at IDX 0.
- WT_LZ_BLANK_EN defined, HOUR = 5 -> hour tens slot DIGIT_SEL = 111111; then 101111 with BCD 5. Undefined -> 011111 with BCD 0.
